// File: rtl/bfp16_pkg.sv
// rtl/bfp16_pkg.sv - shared BF16 constants and packed types for the normalise/pack stage
// Contents: field widths, the all-ones exponent code, the packed BF16 word and the flag word.
package bfp16_pkg;

    localparam int SIZE_EXP  = 8;
    localparam int SIZE_MAN  = 7;
    localparam int SIZE_LOPD = 8;

    localparam logic [7:0] EXP_INF = 8'hFF;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    typedef struct packed {
        logic overflow_inf;
        logic underflow_flush;
        logic zero;
    } flags_t;

endpackage

// File: rtl/lopd_9bit.sv
// rtl/lopd_9bit.sv - leading-zero counter for the 9 bits below the mantissa carry
// Ports:
//   i_data  [8:0] : {hidden, frac[6:0], guard}
//   o_count [3:0] : zeros above the first set bit, 0..8; 9 when i_data is all zero
module lopd_9bit (
    input  logic [8:0] i_data,
    output logic [3:0] o_count
);

    // Scanning upward lets the highest set bit overwrite any lower hit.
    always_comb begin
        o_count = 4'd9;
        for (int i = 0; i < 9; i++) begin
            if (i_data[i]) begin
                o_count = 4'(8 - i);
            end
        end
    end

endmodule

// File: rtl/bfp16_norm_pack.sv
// rtl/bfp16_norm_pack.sv - two-stage normalise, round and pack of a raw mantissa sum into BF16
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_valid / o_ready     : operand handshake
//   i_sign, i_exp, i_mant : sign, pre-normalisation exponent, {carry, hidden, frac, guard}
//   o_valid / i_ready     : result handshake
//   o_result              : packed BF16 {sign, exp, frac}
//   o_flags               : {overflow_inf, underflow_flush, zero}
module bfp16_norm_pack #(
    parameter int SIZE_EXP  = bfp16_pkg::SIZE_EXP,
    parameter int SIZE_MAN  = bfp16_pkg::SIZE_MAN,
    parameter int SIZE_LOPD = bfp16_pkg::SIZE_LOPD
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_sign,
    input  logic [SIZE_EXP-1:0] i_exp,
    input  logic [SIZE_MAN+2:0] i_mant,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [15:0]         o_result,
    output logic [2:0]          o_flags
);

    import bfp16_pkg::*;

    // One spare bit above the exponent catches both overflow and wrap below zero.
    localparam int EW = SIZE_EXP + 1;

    // Stage 1 registers; the carry bit lives in r_ovf so r_mant keeps only the 9 bits below it.
    logic                 r_s1_valid;
    logic                 r_sign;
    logic                 r_ovf;
    logic                 r_zero;
    logic [SIZE_EXP-1:0]  r_exp;
    logic [SIZE_MAN+1:0]  r_mant;
    logic [SIZE_LOPD-1:0] r_lz;

    // Stage 2 / output registers
    logic                 r_o_valid;
    bf16_t                r_result;
    flags_t               r_flags;

    logic                 w_s2_en;
    logic                 w_s1_advance;
    logic                 w_accept;
    logic [3:0]           w_lz;

    logic [SIZE_MAN:0]    w_fg;        // {frac, guard} after alignment
    logic [EW-1:0]        w_exp_n;
    logic [EW-1:0]        w_exp_r;
    logic [SIZE_MAN:0]    w_frac_sum;
    logic [SIZE_MAN-1:0]  w_frac;
    logic                 w_uflow;
    logic                 w_oflow;
    bf16_t                w_res;
    flags_t               w_flg;

    // Handshake: each stage loads when empty or when its downstream moves.
    assign w_s2_en      = ~r_o_valid | i_ready;
    assign w_s1_advance = r_s1_valid & w_s2_en;
    assign o_ready      = ~r_s1_valid | w_s1_advance;
    assign w_accept     = i_valid & o_ready;

    lopd_9bit u_lopd (
        .i_data  (i_mant[SIZE_MAN+1:0]),
        .o_count (w_lz)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
        end else if (o_ready) begin
            r_s1_valid <= i_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_sign <= i_sign;
            r_exp  <= i_exp;
            r_mant <= i_mant[SIZE_MAN+1:0];
            r_ovf  <= i_mant[SIZE_MAN+2];
            r_zero <= (i_mant == '0);
            r_lz   <= SIZE_LOPD'(w_lz);
        end
    end

    // Alignment and exponent adjustment. The hidden bit is implicit after alignment,
    // so only {frac, guard} is carried forward; the left shift therefore works on 8 bits.
    always_comb begin
        w_fg    = '0;
        w_exp_n = '0;
        if (r_ovf) begin
            // Carry out: move right one place, the dropped bit becomes sticky in guard.
            w_fg    = {r_mant[SIZE_MAN+1:2], r_mant[1] | r_mant[0]};
            w_exp_n = {1'b0, r_exp} + EW'(1);
        end else begin
            w_fg    = r_mant[SIZE_MAN:0] << r_lz;
            w_exp_n = {1'b0, r_exp} - EW'(r_lz);
        end
    end

    // Round to nearest, ties away: guard is simply added to the fraction.
    always_comb begin
        w_frac_sum = {1'b0, w_fg[SIZE_MAN:1]} + (SIZE_MAN+1)'(w_fg[0]);
        if (w_frac_sum[SIZE_MAN]) begin
            w_frac  = '0;
            w_exp_r = w_exp_n + EW'(1);
        end else begin
            w_frac  = w_frac_sum[SIZE_MAN-1:0];
            w_exp_r = w_exp_n;
        end
    end

    // Underflow is decided before overflow: on that path w_exp_r has wrapped and is meaningless.
    assign w_uflow = ~r_ovf & ({1'b0, r_exp} <= EW'(r_lz));
    assign w_oflow = (r_exp == EXP_INF) | (w_exp_r >= EW'(EXP_INF));

    always_comb begin
        w_res = '0;
        w_flg = '0;
        if (r_zero) begin
            w_flg.zero = 1'b1;
        end else if (w_uflow) begin
            w_flg.underflow_flush = 1'b1;
        end else if (w_oflow) begin
            w_res.sign         = r_sign;
            w_res.exp          = EXP_INF;
            w_flg.overflow_inf = 1'b1;
        end else begin
            w_res.sign = r_sign;
            w_res.exp  = w_exp_r[SIZE_EXP-1:0];
            w_res.frac = w_frac;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_o_valid <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
        end else if (w_s2_en) begin
            r_o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_flags  <= w_flg;
            end
        end
    end

    assign o_valid  = r_o_valid;
    assign o_result = r_result;
    assign o_flags  = r_flags;

endmodule

// File: tb/tb_bfp16_norm_pack.sv
// tb/tb_bfp16_norm_pack.sv - scoreboard bench for bfp16_norm_pack
module tb_bfp16_norm_pack;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_sign;
    logic [7:0]  i_exp;
    logic [9:0]  i_mant;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_result;
    logic [2:0]  o_flags;

    always #5 clk = ~clk;

    bfp16_norm_pack dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sign   (i_sign),
        .i_exp    (i_exp),
        .i_mant   (i_mant),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_flags  (o_flags)
    );

    typedef struct {
        logic [15:0] res;
        logic [2:0]  fl;
        int          acyc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        stall_q;
    logic [15:0] res_q;
    logic [2:0]  fl_q;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: value-level normalisation with integers, flags {inf, flush, zero}.
    function automatic logic [18:0] model(input logic s, input logic [7:0] e, input logic [9:0] m);
        int mv, p, lz, ex, keep, rnd, sig, sh;
        mv = int'(m);
        ex = int'(e);
        if (mv == 0) return {3'b001, 16'h0000};
        p = 9;
        while (((mv >> p) & 1) == 0) p--;
        if (p == 9) begin
            ex   = ex + 1;
            keep = mv >> 2;
            rnd  = ((mv & 3) != 0) ? 1 : 0;
        end else begin
            lz = 8 - p;
            if (ex <= lz) return {3'b010, 16'h0000};
            ex   = ex - lz;
            sh   = mv << lz;
            keep = sh >> 1;
            rnd  = sh & 1;
        end
        sig = keep + rnd;
        if (sig >= 256) begin
            sig = sig >> 1;
            ex  = ex + 1;
        end
        if (e == 8'hFF || ex >= 255) return {3'b100, s, 8'hFF, 7'h00};
        return {3'b000, s, 8'(ex), 7'(sig & 127)};
    endfunction

    task automatic push(input logic [15:0] res, input logic [2:0] fl, input bit lat);
        sb.push_back('{res, fl, cyc, lat});
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [9:0] m,
                        input logic [15:0] res, input logic [2:0] fl, input bit lat);
        int w;
        i_valid = 1'b1;
        i_sign  = s;
        i_exp   = e;
        i_mant  = m;
        w = 0;
        @(negedge clk);
        while (!o_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!o_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: o_ready=0 after %0d cycles, want 1", w);
        end else begin
            push(res, fl, lat);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic rand_op();
        case ($urandom_range(0, 3))
            0:       i_exp = 8'($urandom_range(0, 12));
            1:       i_exp = 8'($urandom_range(248, 255));
            default: i_exp = 8'($urandom);
        endcase
        case ($urandom_range(0, 4))
            0:       i_mant = 10'd0;
            1:       i_mant = 10'd1 << $urandom_range(0, 9);
            2:       i_mant = {2'b01, 8'hFF};
            default: i_mant = 10'($urandom);
        endcase
        i_sign = 1'($urandom);
    endtask

    task automatic drain();
        int w;
        i_valid = 1'b0;
        i_ready = 1'b1;
        w = 0;
        while (sb.size() != 0 && w < 40) begin
            @(posedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: pops on every output transfer and watches that stalled outputs hold.
    initial begin : monitor
        exp_t e;
        stall_q = 1'b0;
        res_q   = '0;
        fl_q    = '0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    check("hold_valid", o_valid, 1);
                    check("hold_result", o_result, res_q);
                    check("hold_flags", o_flags, fl_q);
                end
                if (o_valid && i_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_output: got %04h with nothing outstanding", o_result);
                    end else begin
                        e = sb.pop_front();
                        check("result", o_result, e.res);
                        check("flags", o_flags, e.fl);
                        if (e.lat) check("latency", cyc - e.acyc, 2);
                    end
                end
                stall_q = o_valid && !i_ready;
                res_q   = o_result;
                fl_q    = o_flags;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        logic [18:0] x;
        bit          acc;

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_sign  = 1'b0;
        i_exp   = '0;
        i_mant  = '0;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(negedge clk);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_result", o_result, 0);
        check("rst_o_flags", o_flags, 0);
        check("rst_o_ready", o_ready, 1);
        @(posedge clk);
        #1;

        // Directed points, no backpressure, latency checked
        i_ready = 1'b1;
        send(0, 8'h7F, 10'b01_0000000_0, 16'h3F80, 3'b000, 1);
        send(0, 8'h7F, 10'b10_0000000_0, 16'h4000, 3'b000, 1);
        send(0, 8'hFE, 10'b10_0000000_0, 16'h7F80, 3'b100, 1);
        send(0, 8'h7F, 10'b00_0010000_0, 16'h3E00, 3'b000, 1);
        send(0, 8'h02, 10'b00_0010000_0, 16'h0000, 3'b010, 1);
        send(0, 8'h03, 10'b00_0010000_0, 16'h0000, 3'b010, 1);
        send(0, 8'h04, 10'b00_0010000_0, 16'h0080, 3'b000, 1);
        send(0, 8'h7F, 10'b01_1111111_1, 16'h4000, 3'b000, 1);
        send(0, 8'hFE, 10'b01_1111111_1, 16'h7F80, 3'b100, 1);
        send(1, 8'h7F, 10'b00_0000000_0, 16'h0000, 3'b001, 1);
        send(1, 8'h7F, 10'b01_1000000_1, 16'hBFC1, 3'b000, 1);
        send(1, 8'hFF, 10'b01_0000000_0, 16'hFF80, 3'b100, 1);
        send(0, 8'h00, 10'b10_0000001_0, 16'h0081, 3'b000, 1);
        send(0, 8'h7F, 10'b00_0000000_1, 16'h3B80, 3'b000, 1);
        drain();

        // Backpressure: i_ready low for five cycles with operands offered every cycle
        i_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (!i_valid) begin
                rand_op();
                i_valid = 1'b1;
            end
            @(negedge clk);
            check($sformatf("bp_ready_%0d", c), o_ready, (c < 2) ? 1 : 0);
            acc = i_valid && o_ready;
            if (acc) begin
                x = model(i_sign, i_exp, i_mant);
                push(x[15:0], x[18:16], 0);
            end
            @(posedge clk);
            #1;
            if (acc) i_valid = 1'b0;
        end
        i_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_op();
            x = model(i_sign, i_exp, i_mant);
            send(i_sign, i_exp, i_mant, x[15:0], x[18:16], 0);
        end
        drain();

        // Reset with two operands in flight
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_sign  = 1'b0;
        i_exp   = 8'h7F;
        i_mant  = 10'b01_0000000_0;
        @(negedge clk);
        check("inflight_accept_a", o_ready, 1);
        @(posedge clk);
        #1;
        i_mant = 10'b10_0000000_0;
        i_rst  = 1'b1;
        @(negedge clk);
        check("inflight_no_valid", o_valid, 0);
        @(posedge clk);
        #1;
        i_rst   = 1'b0;
        i_valid = 1'b0;
        sb.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("postrst_no_valid_%0d", c), o_valid, 0);
            check($sformatf("postrst_ready_%0d", c), o_ready, 1);
        end
        @(posedge clk);
        #1;
        send(1, 8'h80, 10'b01_0000000_0, 16'hC000, 3'b000, 1);
        drain();

        // Randomised traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            if (!i_valid && $urandom_range(0, 3) != 0) begin
                rand_op();
                i_valid = 1'b1;
            end
            @(negedge clk);
            acc = i_valid && o_ready;
            if (acc) begin
                x = model(i_sign, i_exp, i_mant);
                push(x[15:0], x[18:16], 0);
            end
            @(posedge clk);
            #1;
            if (acc) i_valid = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
